// File: rtl/jtcontra_gfx_romarb_if.sv
// jtcontra_gfx_romarb_if
// Bundles the two fetcher ports and the SDRAM slot port of the graphics ROM
// arbiter.
//   scr_*  : tilemap fetcher  (cs/addr in, ok/data out)
//   obj_*  : object fetcher   (cs/addr in, ok/data out)
//   rom_*  : SDRAM slot       (cs/addr out, ok/data in)
// Modport "slave" is taken by the arbiter. Modport "master" is taken by
// whatever drives the fetcher requests and the SDRAM response.
interface jtcontra_gfx_romarb_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic          scr_cs;
  logic [AW-1:0] scr_addr;
  logic          scr_ok;
  logic [DW-1:0] scr_data;
  logic          obj_cs;
  logic [AW-1:0] obj_addr;
  logic          obj_ok;
  logic [DW-1:0] obj_data;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic          rom_ok;
  logic [DW-1:0] rom_data;

  modport slave (
    input  scr_cs, scr_addr, obj_cs, obj_addr, rom_ok, rom_data,
    output scr_ok, scr_data, obj_ok, obj_data, rom_cs, rom_addr
  );

  modport master (
    output scr_cs, scr_addr, obj_cs, obj_addr, rom_ok, rom_data,
    input  scr_ok, scr_data, obj_ok, obj_data, rom_cs, rom_addr
  );
endinterface

// File: rtl/jtcontra_gfx_romarb.sv
// jtcontra_gfx_romarb
// Shares one SDRAM graphics ROM slot between the tilemap (SCR) and object
// (OBJ) fetchers of a 007121 layer. SCR has priority during the active line
// (LHBL=1), OBJ during H-blank. A requester that loses STARVE arbitrations in
// a row gets the next grant regardless of the video phase.
// Ports:
//   rst    async reset, active-high
//   clk    rising-edge clock
//   LHBL   1 = active line, 0 = H-blank
//   bus    fetcher and SDRAM signals (slave side)
//   owner  last granted requester (0 = SCR, 1 = OBJ)
//   busy   a fetch is in progress
module jtcontra_gfx_romarb #(
  parameter int AW     = 18,
  parameter int DW     = 16,
  parameter int STARVE = 4
) (
  input  logic                      rst,
  input  logic                      clk,
  input  logic                      LHBL,
  jtcontra_gfx_romarb_if.slave      bus,
  output logic                      owner,
  output logic                      busy
);

  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_C = CW'(STARVE);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DONE} state_e;

  state_e        state_q,    state_d;
  logic          rom_cs_q,   rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          scr_ok_q,   scr_ok_d;
  logic          obj_ok_q,   obj_ok_d;
  logic [DW-1:0] scr_data_q, scr_data_d;
  logic [DW-1:0] obj_data_q, obj_data_d;
  logic          owner_q,    owner_d;
  logic [CW-1:0] scr_cnt_q,  scr_cnt_d;
  logic [CW-1:0] obj_cnt_q,  obj_cnt_d;

  logic          scr_elig, obj_elig, win_obj;
  logic          own_cs;
  logic [AW-1:0] own_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      scr_ok_q   <= 1'b0;
      obj_ok_q   <= 1'b0;
      scr_data_q <= '0;
      obj_data_q <= '0;
      owner_q    <= 1'b0;
      scr_cnt_q  <= '0;
      obj_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      scr_ok_q   <= scr_ok_d;
      obj_ok_q   <= obj_ok_d;
      scr_data_q <= scr_data_d;
      obj_data_q <= obj_data_d;
      owner_q    <= owner_d;
      scr_cnt_q  <= scr_cnt_d;
      obj_cnt_q  <= obj_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    scr_ok_d   = scr_ok_q;
    obj_ok_d   = obj_ok_q;
    scr_data_d = scr_data_q;
    obj_data_d = obj_data_q;
    owner_d    = owner_q;
    scr_cnt_d  = scr_cnt_q;
    obj_cnt_d  = obj_cnt_q;

    scr_elig = bus.scr_cs & ~scr_ok_q;
    obj_elig = bus.obj_cs & ~obj_ok_q;
    win_obj  = 1'b0;
    own_cs   = owner_q ? bus.obj_cs   : bus.scr_cs;
    own_addr = owner_q ? bus.obj_addr : bus.scr_addr;

    unique case (state_q)
      S_IDLE: begin
        if (scr_elig || obj_elig) begin
          if (scr_elig && obj_elig) begin
            // Video phase picks the winner unless the loser has starved
            win_obj = ~LHBL;
            if (LHBL && obj_cnt_q == STARVE_C)
              win_obj = 1'b1;
            else if (!LHBL && scr_cnt_q == STARVE_C)
              win_obj = 1'b0;
          end else begin
            win_obj = obj_elig;
          end

          if (win_obj) begin
            obj_cnt_d = '0;
            if (scr_elig && scr_cnt_q != STARVE_C) scr_cnt_d = scr_cnt_q + 1'b1;
          end else begin
            scr_cnt_d = '0;
            if (obj_elig && obj_cnt_q != STARVE_C) obj_cnt_d = obj_cnt_q + 1'b1;
          end

          rom_addr_d = win_obj ? bus.obj_addr : bus.scr_addr;
          owner_d    = win_obj;
          rom_cs_d   = 1'b1;
          state_d    = S_ARM;
        end
      end

      S_ARM, S_WAIT: begin
        if (!own_cs) begin
          rom_cs_d = 1'b0;
          state_d  = S_IDLE;
        end else if (own_addr != rom_addr_q) begin
          // Any rom_ok seen this cycle belongs to the old address
          rom_addr_d = own_addr;
          state_d    = S_ARM;
        end else if (state_q == S_ARM) begin
          // rom_ok may still reflect the previous address here
          state_d = S_WAIT;
        end else if (bus.rom_ok) begin
          if (owner_q) begin
            obj_data_d = bus.rom_data;
            obj_ok_d   = 1'b1;
          end else begin
            scr_data_d = bus.rom_data;
            scr_ok_d   = 1'b1;
          end
          rom_cs_d = 1'b0;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (!own_cs || own_addr != rom_addr_q) begin
          scr_ok_d = 1'b0;
          obj_ok_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.rom_cs   = rom_cs_q;
    bus.rom_addr = rom_addr_q;
    bus.scr_ok   = scr_ok_q;
    bus.scr_data = scr_data_q;
    bus.obj_ok   = obj_ok_q;
    bus.obj_data = obj_data_q;
    owner        = owner_q;
    busy         = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// tb_jtcontra_gfx_romarb
// Directed scenarios followed by randomized traffic from both fetchers.
// Expected data is queued per fetcher when a request is issued; a monitor
// pops on each ok rising edge. Grants are checked against a priority model
// built from the arbitration rules (phase priority + starvation counters).
module tb_jtcontra_gfx_romarb;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic LHBL = 1'b1;
  logic owner, busy;

  jtcontra_gfx_romarb_if #(.AW(AW), .DW(DW)) bus ();

  jtcontra_gfx_romarb #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .rst   (rst),
    .clk   (clk),
    .LHBL  (LHBL),
    .bus   (bus.slave),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Fetcher request drivers
  logic          req_cs   [2];
  logic [AW-1:0] req_addr [2];
  assign bus.scr_cs   = req_cs[0];
  assign bus.scr_addr = req_addr[0];
  assign bus.obj_cs   = req_cs[1];
  assign bus.obj_addr = req_addr[1];

  // ROM content
  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {14'd0, a} * 32'h9E3779B1;
    return t[31:16] ^ a[15:0];
  endfunction

  // SDRAM model: responds some cycles after it sees a new address; while
  // idle it keeps presenting its last (possibly stale) ok/data.
  int            lat_min = 0, lat_max = 2;
  logic [AW-1:0] sd_addr;
  logic          sd_valid, sd_ok;
  logic [DW-1:0] sd_data;
  int            sd_cnt;
  assign bus.rom_ok   = sd_ok;
  assign bus.rom_data = sd_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_addr <= '0; sd_valid <= 1'b0; sd_ok <= 1'b0; sd_data <= '0; sd_cnt <= 0;
    end else if (bus.rom_cs) begin
      if (!sd_valid || bus.rom_addr != sd_addr) begin
        sd_addr  <= bus.rom_addr;
        sd_valid <= 1'b1;
        sd_cnt   <= $urandom_range(lat_max, lat_min);
        if (lat_max == 0) begin
          sd_ok   <= 1'b1;
          sd_data <= romf(bus.rom_addr);
        end else begin
          sd_ok   <= 1'b0;
        end
      end else if (sd_cnt > 0) begin
        sd_cnt <= sd_cnt - 1;
      end else begin
        sd_ok   <= 1'b1;
        sd_data <= romf(sd_addr);
      end
    end
  end

  // Scoreboard state
  logic [DW-1:0] scr_q[$];
  logic [DW-1:0] obj_q[$];
  logic          glog[$];
  int  n_chk = 0, n_fail = 0;
  int  exp_lat [2] = '{0, 0};
  bit  chk_starve = 0, final_chk = 0, final_done = 0, stall_flag = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void push_exp(input int w, input logic [DW-1:0] d);
    if (w == 0) scr_q.push_back(d); else obj_q.push_back(d);
  endfunction

  function automatic void drop_exp(input int w);
    if (w == 0) begin if (scr_q.size() > 0) void'(scr_q.pop_back()); end
    else        begin if (obj_q.size() > 0) void'(obj_q.pop_back()); end
  endfunction

  function automatic int q_size(input int w);
    return (w == 0) ? scr_q.size() : obj_q.size();
  endfunction

  function automatic logic [DW-1:0] q_pop(input int w);
    if (w == 0) return scr_q.pop_front();
    return obj_q.pop_front();
  endfunction

  // Monitor
  initial begin : monitor
    logic          p_cs [2];
    logic [AW-1:0] p_addr [2];
    logic          p_ok [2];
    logic          okv [2];
    logic [DW-1:0] dv [2];
    int            lat_n [2], wait_n [2], m_cnt [2];
    logic          busy_p, p_lhbl, wo, e0, e1;
    busy_p = 0; p_lhbl = 1;
    for (int w = 0; w < 2; w++) begin
      p_cs[w] = 0; p_addr[w] = '0; p_ok[w] = 0; lat_n[w] = 0; wait_n[w] = 0; m_cnt[w] = 0;
    end
    forever begin
      @(negedge clk);
      okv[0] = bus.scr_ok;   okv[1] = bus.obj_ok;
      dv[0]  = bus.scr_data; dv[1]  = bus.obj_data;
      if (rst) begin
        chk("rst_rom_cs", bus.rom_cs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_scr_ok", okv[0], 0);
        chk("rst_obj_ok", okv[1], 0);
        chk("rst_owner", owner, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_data", {dv[0], dv[1]}, 0);
        busy_p = 0;
        for (int w = 0; w < 2; w++) begin
          p_cs[w] = 0; p_ok[w] = 0; lat_n[w] = 0; wait_n[w] = 0; m_cnt[w] = 0;
        end
      end else begin
        chk("ok_exclusive", okv[0] & okv[1], 0);

        if (busy && !busy_p) begin
          e0 = p_cs[0]; e1 = p_cs[1];
          if (!e0 && !e1) begin
            chk("grant_without_request", 1, 0);
          end else begin
            if (e0 && e1) begin
              wo = !p_lhbl;
              if (p_lhbl && m_cnt[1] == STARVE) wo = 1;
              if (!p_lhbl && m_cnt[0] == STARVE) wo = 0;
              m_cnt[wo]  = 0;
              m_cnt[!wo] = (m_cnt[!wo] < STARVE) ? m_cnt[!wo] + 1 : STARVE;
            end else begin
              wo = e1;
              m_cnt[wo] = 0;
            end
            chk("grant_owner", owner, wo);
            chk("grant_addr", bus.rom_addr, p_addr[wo]);
            glog.push_back(wo);
          end
        end

        if (chk_starve && glog.size() == 5) begin
          for (int i = 0; i < 5; i++) chk("starve_order", glog[i], (i == 4) ? 1 : 0);
          chk_starve = 0;
        end

        for (int w = 0; w < 2; w++) begin
          if (req_cs[w] && (!p_cs[w] || req_addr[w] != p_addr[w])) lat_n[w] = 0;
          else lat_n[w]++;
          if (okv[w] && !p_ok[w]) begin
            if (q_size(w) == 0) chk((w == 0) ? "scr_ok_spurious" : "obj_ok_spurious", 1, 0);
            else chk((w == 0) ? "scr_data" : "obj_data", dv[w], q_pop(w));
            chk((w == 0) ? "scr_rom_addr" : "obj_rom_addr", bus.rom_addr, req_addr[w]);
            chk((w == 0) ? "scr_owner" : "obj_owner", owner, w);
            chk("ok_min_latency", (lat_n[w] >= 3) ? 1 : 0, 1);
            if (exp_lat[w] != 0) chk("ok_latency", lat_n[w], exp_lat[w]);
          end
          if (req_cs[w] && !okv[w]) wait_n[w]++; else wait_n[w] = 0;
          if (wait_n[w] == 400) chk((w == 0) ? "scr_timeout" : "obj_timeout", 0, 1);
        end

        if (stall_flag) begin
          chk("idle_timeout", 0, 1);
          stall_flag = 0;
        end
      end

      if (final_chk && !final_done) begin
        chk("scr_queue_empty", scr_q.size(), 0);
        chk("obj_queue_empty", obj_q.size(), 0);
        final_done = 1;
      end

      for (int w = 0; w < 2; w++) begin
        p_cs[w] = rst ? 1'b0 : req_cs[w];
        p_addr[w] = req_addr[w];
        p_ok[w] = okv[w];
      end
      busy_p = rst ? 1'b0 : busy;
      p_lhbl = LHBL;
    end
  end

  // One fetcher transaction. abort_at/retgt_at count cycles after issue.
  task automatic fetch(input int w, input logic [AW-1:0] a, input int hold,
                       input int retgt_at, input logic [AW-1:0] ra,
                       input int abort_at, input bit drop);
    logic got;
    got = 0;
    req_cs[w] = 1; req_addr[w] = a;
    push_exp(w, romf(a));
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk); #1;
      if ((w == 0) ? bus.scr_ok : bus.obj_ok) begin got = 1; break; end
      if (n == abort_at) begin
        req_cs[w] = 0;
        drop_exp(w);
        return;
      end
      if (n == retgt_at) begin
        req_addr[w] = ra;
        drop_exp(w);
        push_exp(w, romf(ra));
      end
    end
    if (got) repeat (hold) begin @(posedge clk); #1; end
    if (drop || !got) req_cs[w] = 0;
  endtask

  task automatic idle_wait();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (!busy && !req_cs[0] && !req_cs[1]) begin ok = 1; break; end
    end
    if (!ok) stall_flag = 1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic rand_loop(input int w, input int iters);
    logic [AW-1:0] a, ra;
    int r, ab, rt;
    bit drop;
    a = AW'($urandom);
    for (int i = 0; i < iters; i++) begin
      r = $urandom_range(9);
      ab = -1; rt = -1;
      if (r == 0) ab = $urandom_range(5, 1);
      else if (r == 1) rt = $urandom_range(4, 1);
      ra = a ^ AW'($urandom_range(262143, 1));
      drop = (i == iters - 1) || ($urandom_range(1) == 1);
      fetch(w, a, $urandom_range(3, 1), rt, ra, ab, drop);
      if (!req_cs[w]) repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      a = req_addr[w] ^ AW'($urandom_range(262143, 1));
    end
    req_cs[w] = 0;
  endtask

  initial begin : stimulus
    bit rand_done, up;
    req_cs[0] = 0; req_cs[1] = 0;
    req_addr[0] = '0; req_addr[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Simultaneous requests during the active line: SCR first
    LHBL = 1;
    fork
      fetch(0, 18'h01234, 2, -1, '0, -1, 1);
      fetch(1, 18'h20000, 1, -1, '0, -1, 1);
    join
    idle_wait();

    // Same during H-blank: OBJ first
    LHBL = 0;
    fork
      fetch(0, 18'h01234, 2, -1, '0, -1, 1);
      fetch(1, 18'h20000, 1, -1, '0, -1, 1);
    join
    idle_wait();
    LHBL = 1;

    // rom_ok stuck high: the stale ARM-cycle ok must be ignored
    lat_min = 0; lat_max = 0;
    fetch(1, 18'h15555, 1, -1, '0, -1, 1);
    idle_wait();
    exp_lat[0] = 3;
    fetch(0, 18'h0ABCD, 1, -1, '0, -1, 1);
    exp_lat[0] = 0;
    idle_wait();

    // Retarget in WAIT
    lat_min = 4; lat_max = 4;
    fetch(0, 18'h00010, 1, 2, 18'h00011, -1, 1);
    idle_wait();

    // Starvation: SCR keeps re-requesting, OBJ held
    lat_min = 1; lat_max = 2;
    LHBL = 1;
    glog.delete();
    chk_starve = 1;
    fork
      begin
        for (int i = 0; i < 6; i++) fetch(0, 18'h00100 + AW'(i), 1, -1, '0, -1, (i == 5));
      end
      fetch(1, 18'h2F0F0, 1, -1, '0, -1, 1);
    join
    idle_wait();

    // Async reset in WAIT
    lat_min = 6; lat_max = 6;
    req_cs[0] = 1; req_addr[0] = 18'h1F00F;
    push_exp(0, romf(18'h1F00F));
    up = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (busy) begin up = 1; break; end
    end
    if (up) begin @(posedge clk); #1; end
    #1 rst = 1;
    req_cs[0] = 0;
    scr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    lat_min = 0; lat_max = 3;
    fetch(0, 18'h1F00F, 1, -1, '0, -1, 1);
    idle_wait();

    // Randomized traffic with LHBL toggling
    rand_done = 0;
    fork
      begin
        fork
          rand_loop(0, 60);
          rand_loop(1, 60);
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          if ($urandom_range(15) == 0) LHBL = ~LHBL;
        end
      end
    join
    idle_wait();

    final_chk = 1;
    for (int n = 0; n < 10 && !final_done; n++) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
